// File: rtl/cc_pkg.sv
// Shared types and constants for the cache-line refill path.
package cc_pkg;

    localparam int unsigned CC_BEAT_W = 64;
    localparam int unsigned CC_BEATS  = 8;
    localparam int unsigned CC_LINE_W = 512;
    localparam int unsigned CC_FIFO_W = 518;
    localparam int unsigned CC_IDX_W  = 3;

    typedef enum logic [1:0] {DS_IDLE, DS_FILL, DS_PUSH} cc_deser_state_t;

    // Word 0 occupies the most significant 64 bits of the line.
    function automatic int unsigned cc_word_lsb(input logic [CC_IDX_W-1:0] w);
        return CC_LINE_W - CC_BEAT_W - (CC_BEAT_W * 32'(w));
    endfunction

endpackage

// File: rtl/cc_deserializer.sv
// Assembles 8 critical-word-first read beats into one 512-bit line and pushes it to the refill FIFO.
// Optional macro CC_DESER_CW_BYPASS_EN forwards the critical word on the beat-0 handshake.
module cc_deserializer
    import cc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic [CC_IDX_W-1:0]  offset_i,
    output logic                 busy_o,
    input  logic [CC_BEAT_W-1:0] rdata_i,
    input  logic                 rlast_i,
    input  logic                 rvalid_i,
    output logic                 rready_o,
    input  logic                 fifo_full_i,
    output logic                 fifo_wren_o,
    output logic [CC_FIFO_W-1:0] fifo_wdata_o,
    output logic                 err_o,
    output logic                 cw_valid_o,
    output logic [CC_BEAT_W-1:0] cw_data_o
);

    cc_deser_state_t       state_q, state_d;
    logic [CC_IDX_W-1:0]   cnt_q, cnt_d;
    logic [CC_IDX_W-1:0]   off_q, off_d;
    logic [CC_BEAT_W-1:0]  words_q [CC_BEATS];
    logic [CC_LINE_W-1:0]  line;
    logic [CC_BEATS-1:0]   word_we;
    logic [CC_IDX_W-1:0]   word_idx;
    logic                  beat_hs;
    logic                  last_cnt;

    assign beat_hs  = (state_q == DS_FILL) && rvalid_i;
    assign last_cnt = (cnt_q == 3'd7);
    // Critical-word-first wrap relies on natural 3-bit overflow.
    assign word_idx = off_q + cnt_q;

    // State, beat counter and offset registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DS_IDLE;
            cnt_q   <= '0;
            off_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            off_q   <= off_d;
        end
    end

    // Next-state and handshake decode
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        off_d       = off_q;
        rready_o    = 1'b0;
        fifo_wren_o = 1'b0;
        err_o       = 1'b0;
        case (state_q)
            DS_IDLE: begin
                if (start_i) begin
                    state_d = DS_FILL;
                    off_d   = offset_i;
                    cnt_d   = '0;
                end
            end
            DS_FILL: begin
                rready_o = 1'b1;
                if (beat_hs) begin
                    cnt_d = cnt_q + 3'd1;
                    if (rlast_i || last_cnt) begin
                        state_d = DS_PUSH;
                        err_o   = (rlast_i != last_cnt);
                    end
                end
            end
            DS_PUSH: begin
                if (!fifo_full_i) begin
                    fifo_wren_o = 1'b1;
                    state_d     = DS_IDLE;
                end
            end
            default: state_d = DS_IDLE;
        endcase
    end

    always_comb begin
        word_we = '0;
        for (int j = 0; j < int'(CC_BEATS); j++) begin
            word_we[j] = beat_hs && (word_idx == 3'(j));
        end
    end

    // Line storage; words not written by a short burst keep their old contents
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < int'(CC_BEATS); j++) begin
                words_q[j] <= '0;
            end
        end else begin
            for (int j = 0; j < int'(CC_BEATS); j++) begin
                if (word_we[j]) begin
                    words_q[j] <= rdata_i;
                end
            end
        end
    end

    always_comb begin
        line = '0;
        for (int j = 0; j < int'(CC_BEATS); j++) begin
            line[cc_word_lsb(3'(j)) +: CC_BEAT_W] = words_q[j];
        end
    end

    assign busy_o       = (state_q != DS_IDLE);
    assign fifo_wdata_o = {off_q, 3'b000, line};

`ifdef CC_DESER_CW_BYPASS_EN
    assign cw_valid_o = beat_hs && (cnt_q == 3'd0);
    assign cw_data_o  = cw_valid_o ? rdata_i : '0;
`else
    assign cw_valid_o = 1'b0;
    assign cw_data_o  = '0;
`endif

endmodule

// File: tb/tb_cc_deserializer.sv
// Scoreboard bench for cc_deserializer: driver queues expected FIFO entries, monitor pops on fifo_wren_o.
module tb_cc_deserializer;
    import cc_pkg::*;

    logic                 clk;
    logic                 rst_n;
    logic                 start_i;
    logic [CC_IDX_W-1:0]  offset_i;
    logic                 busy_o;
    logic [CC_BEAT_W-1:0] rdata_i;
    logic                 rlast_i;
    logic                 rvalid_i;
    logic                 rready_o;
    logic                 fifo_full_i;
    logic                 fifo_wren_o;
    logic [CC_FIFO_W-1:0] fifo_wdata_o;
    logic                 err_o;
    logic                 cw_valid_o;
    logic [CC_BEAT_W-1:0] cw_data_o;

    cc_deserializer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .offset_i     (offset_i),
        .busy_o       (busy_o),
        .rdata_i      (rdata_i),
        .rlast_i      (rlast_i),
        .rvalid_i     (rvalid_i),
        .rready_o     (rready_o),
        .fifo_full_i  (fifo_full_i),
        .fifo_wren_o  (fifo_wren_o),
        .fifo_wdata_o (fifo_wdata_o),
        .err_o        (err_o),
        .cw_valid_o   (cw_valid_o),
        .cw_data_o    (cw_data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [CC_FIFO_W-1:0] exp_q [$];
    logic [CC_BEAT_W-1:0] model_words [CC_BEATS];

    task automatic chk(input string name, input logic [CC_FIFO_W-1:0] act, input logic [CC_FIFO_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [CC_FIFO_W-1:0] exp_entry(input logic [2:0] off);
        logic [CC_LINE_W-1:0] l;
        l = '0;
        for (int j = 0; j < 8; j++) begin
            l[448 - 64*j +: 64] = model_words[j];
        end
        return {off, 3'b000, l};
    endfunction

    // Monitor: every FIFO write must match the oldest queued expectation
    always @(negedge clk) begin
        if (rst_n && fifo_wren_o) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 518'(fifo_wren_o), 518'(0));
            end else begin
                chk("fifo_entry", fifo_wdata_o, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 518'(busy_o), 518'(0));
        chk({tag, "_rready"}, 518'(rready_o), 518'(0));
        chk({tag, "_wren"}, 518'(fifo_wren_o), 518'(0));
        chk({tag, "_wdata"}, fifo_wdata_o, 518'(0));
        chk({tag, "_err"}, 518'(err_o), 518'(0));
        chk({tag, "_cwv"}, 518'(cw_valid_o), 518'(0));
        chk({tag, "_cwd"}, 518'(cw_data_o), 518'(0));
    endtask

    // Drives one miss: nbeats beats from base, rlast on the final beat if use_rlast,
    // FIFO full for full_cycles cycles after the closing beat.
    task automatic send_line(input logic [2:0] off, input logic [63:0] base, input int nbeats,
                             input bit use_rlast, input int full_cycles);
        logic [63:0] d;
        logic [2:0]  w;
        bit          closing;
        bit          exp_err;
        start_i  = 1'b1;
        offset_i = off;
        @(negedge clk);
        chk("idle_busy", 518'(busy_o), 518'(0));
        chk("idle_rready", 518'(rready_o), 518'(0));
        tick();
        start_i = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            d        = base + 64'(i);
            rvalid_i = 1'b1;
            rdata_i  = d;
            rlast_i  = use_rlast && (i == nbeats - 1);
            fifo_full_i = (i == nbeats - 1) && (full_cycles > 0);
            // start_i during a fill must be ignored
            if (i == 1) begin
                start_i  = 1'b1;
                offset_i = ~off;
            end
            closing = rlast_i || (i == 7);
            exp_err = closing && (rlast_i != (i == 7));
            @(negedge clk);
            chk("fill_rready", 518'(rready_o), 518'(1));
            chk("fill_busy", 518'(busy_o), 518'(1));
            chk("err_pulse", 518'(err_o), 518'(exp_err));
`ifdef CC_DESER_CW_BYPASS_EN
            chk("cw_valid", 518'(cw_valid_o), 518'(i == 0));
            chk("cw_data", 518'(cw_data_o), (i == 0) ? 518'(d) : 518'(0));
`else
            chk("cw_valid", 518'(cw_valid_o), 518'(0));
            chk("cw_data", 518'(cw_data_o), 518'(0));
`endif
            w = off + 3'(i);
            model_words[w] = d;
            if (closing) exp_q.push_back(exp_entry(off));
            tick();
            start_i = 1'b0;
        end
        rvalid_i = 1'b0;
        rlast_i  = 1'b0;
        for (int k = 0; k < full_cycles; k++) begin
            @(negedge clk);
            chk("full_wren", 518'(fifo_wren_o), 518'(0));
            chk("full_rready", 518'(rready_o), 518'(0));
            chk("full_busy", 518'(busy_o), 518'(1));
            tick();
        end
        fifo_full_i = 1'b0;
        @(negedge clk);
        chk("push_wren", 518'(fifo_wren_o), 518'(1));
        chk("push_rready", 518'(rready_o), 518'(0));
        tick();
        @(negedge clk);
        chk("after_push_wren", 518'(fifo_wren_o), 518'(0));
        chk("after_push_busy", 518'(busy_o), 518'(0));
        tick();
    endtask

    // Starts a miss, delivers nbeats beats, then resets the block mid-fill.
    task automatic abort_line(input logic [2:0] off, input logic [63:0] base, input int nbeats);
        start_i  = 1'b1;
        offset_i = off;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            rvalid_i = 1'b1;
            rdata_i  = base + 64'(i);
            tick();
        end
        rvalid_i = 1'b0;
        rst_n    = 1'b0;
        #2;
        chk_all_zero("midreset");
        for (int j = 0; j < 8; j++) model_words[j] = '0;
        tick();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        chk("post_reset_busy", 518'(busy_o), 518'(0));
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n       = 1'b0;
        start_i     = 1'b0;
        offset_i    = '0;
        rdata_i     = '0;
        rlast_i     = 1'b0;
        rvalid_i    = 1'b0;
        fifo_full_i = 1'b0;
        for (int j = 0; j < 8; j++) model_words[j] = '0;
        #3;
        chk_all_zero("reset");
        #9;
        rst_n = 1'b1;
        tick();

        send_line(3'd0, 64'h0,    8, 1'b1, 0);
        send_line(3'd5, 64'hA0,   8, 1'b1, 0);
        send_line(3'd3, 64'h1000, 8, 1'b1, 4);
        send_line(3'd6, 64'h2000, 4, 1'b1, 0);
        send_line(3'd1, 64'h3000, 8, 1'b1, 0);
        send_line(3'd4, 64'h4000, 8, 1'b0, 0);
        abort_line(3'd2, 64'h5000, 4);
        send_line(3'd7, 64'h6000, 3, 1'b1, 0);
        send_line(3'd2, 64'hDEAD, 8, 1'b1, 0);

        repeat (3) tick();
        chk("scoreboard_drained", 518'(exp_q.size()), 518'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
